// File: rtl/dmem_ctrl_if.sv
// MEM-stage <-> data-memory controller bus. The _i/_o suffixes are from the
// controller's point of view.
interface dmem_ctrl_if;
  logic        req_i;
  logic        we_i;
  logic [1:0]  size_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        rvalid_o;
  logic        done_o;
  logic        err_o;

  modport master (
    output req_i,
    output we_i,
    output size_i,
    output addr_i,
    output wdata_i,
    input  stall_o,
    input  rdata_o,
    input  rvalid_o,
    input  done_o,
    input  err_o
  );

  modport slave (
    input  req_i,
    input  we_i,
    input  size_i,
    input  addr_i,
    input  wdata_i,
    output stall_o,
    output rdata_o,
    output rvalid_o,
    output done_o,
    output err_o
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller with an internal single-port word RAM. Loads return the
// raw aligned word; byte/half stores are done as read-modify-write.
module dmem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input logic        clk,
  input logic        rst_n,
  dmem_ctrl_if.slave mem_io
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {StIdle, StLdResp, StRmwWr, StErrResp} state_e;

  state_e        state_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic [AW-1:0] idx_q;
  logic [1:0]    lane_q;
  logic          half_q;
  logic [15:0]   wdata_q;
  logic [31:0]   rmw_word_q;
  logic [31:0]   rdata_q;
  logic          rvalid_q;
  logic          done_q;
  logic          err_q;

  logic          misaligned;
  logic          accept;
  logic          is_word_st;
  logic          is_sub_st;
  logic          is_load;
  logic          stall;
  logic [31:0]   merged;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic          unused_addr_hi;

  // Upper address bits are ignored so the array wraps modulo DEPTH_WORDS*4.
  assign idx            = mem_io.addr_i[AW+1:2];
  assign unused_addr_hi = ^mem_io.addr_i[31:AW+2];

  always_comb begin
    misaligned = 1'b0;
    case (mem_io.size_i)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = mem_io.addr_i[0];
      2'b10:   misaligned = |mem_io.addr_i[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  assign accept     = (state_q == StIdle) && mem_io.req_i && !rst_n;
  assign is_word_st = mem_io.we_i && (mem_io.size_i == 2'b10) && !misaligned;
  assign is_sub_st  = mem_io.we_i && (mem_io.size_i != 2'b10) && !misaligned;
  assign is_load    = !mem_io.we_i && !misaligned;
  // Only aligned word stores complete without freezing the pipeline.
  assign stall      = accept && !is_word_st;

  always_comb begin
    merged = rmw_word_q;
    if (half_q) begin
      if (lane_q[1]) begin
        merged[31:16] = wdata_q;
      end else begin
        merged[15:0] = wdata_q;
      end
    end else begin
      case (lane_q)
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end
  end

  // A reset that lands in StRmwWr returns state to idle first, so the pending
  // merge write is dropped.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = idx;
    mem_wdata = mem_io.wdata_i;
    if (state_q == StRmwWr) begin
      mem_we    = !rst_n;
      mem_waddr = idx_q;
      mem_wdata = merged;
    end else if (accept && is_word_st) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    if (accept && is_sub_st) begin
      rmw_word_q <= mem[idx];
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      lane_q   <= '0;
      half_q   <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        StIdle: begin
          if (mem_io.req_i) begin
            if (misaligned) begin
              state_q <= StErrResp;
              err_q   <= 1'b1;
            end else if (is_load) begin
              state_q  <= StLdResp;
              rdata_q  <= mem[idx];
              rvalid_q <= 1'b1;
            end else if (is_word_st) begin
              done_q <= 1'b1;
            end else begin
              state_q <= StRmwWr;
              idx_q   <= idx;
              lane_q  <= mem_io.addr_i[1:0];
              half_q  <= mem_io.size_i[0];
              wdata_q <= mem_io.wdata_i[15:0];
            end
          end
        end
        StLdResp:  state_q <= StIdle;
        StRmwWr: begin
          state_q <= StIdle;
          done_q  <= 1'b1;
        end
        StErrResp: state_q <= StIdle;
        default:   state_q <= StIdle;
      endcase
    end
  end

  assign mem_io.stall_o  = stall;
  assign mem_io.rdata_o  = rdata_q;
  assign mem_io.rvalid_o = rvalid_q;
  assign mem_io.done_o   = done_q;
  assign mem_io.err_o    = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: inputs change 1 ns after a rising edge, outputs
// are sampled on the falling edge.
module tb_dmem_ctrl;
  localparam int unsigned DEPTH_WORDS = 1024;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  dmem_ctrl_if bus ();

  dmem_ctrl #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mem_io(bus)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic req, input logic we, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_i   = req;
    bus.we_i    = we;
    bus.size_i  = size;
    bus.addr_i  = addr;
    bus.wdata_i = wdata;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic do_sw(input logic [31:0] addr, input logic [31:0] data);
    drive(1'b1, 1'b1, 2'b10, addr, data);
    to_pos();
    idle();
    to_pos();
  endtask

  task automatic do_load(input logic [31:0] addr, output logic st, output logic rv,
                         output logic [31:0] data);
    drive(1'b1, 1'b0, 2'b10, addr, 32'h0);
    @(negedge clk);
    st = bus.stall_o;
    to_pos();
    idle();
    @(negedge clk);
    rv   = bus.rvalid_o;
    data = bus.rdata_o;
    to_pos();
  endtask

  // Sub-word store: stall at accept, stall/done in the merge cycle, done after.
  task automatic do_rmw(input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] data, output logic st_acc,
                        output logic st_wr, output logic dn_wr, output logic dn_after);
    drive(1'b1, 1'b1, size, addr, data);
    @(negedge clk);
    st_acc = bus.stall_o;
    to_pos();
    idle();
    @(negedge clk);
    st_wr = bus.stall_o;
    dn_wr = bus.done_o;
    to_pos();
    @(negedge clk);
    dn_after = bus.done_o;
    to_pos();
  endtask

  task automatic test_reset();
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.stall_o); end
    checks++; if (bus.rvalid_o !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", bus.rvalid_o); end
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done_o); end
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.err_o); end
    checks++; if (bus.rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 00000000", bus.rdata_o); end
    rst_n = 1'b0;
    to_pos();
    @(negedge clk);
    checks++; if ({bus.stall_o, bus.rvalid_o, bus.done_o, bus.err_o} !== 4'b0) begin errors++; $display("FAIL idle_outputs: got %b expected 0000", {bus.stall_o, bus.rvalid_o, bus.done_o, bus.err_o}); end
    to_pos();
  endtask

  task automatic test_word_store_load();
    logic st, rv;
    logic [31:0] d;
    drive(1'b1, 1'b1, 2'b10, 32'h40, 32'hDEADBEEF);
    @(negedge clk);
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL sw_stall: got %b expected 0", bus.stall_o); end
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL sw_done_early: got %b expected 0", bus.done_o); end
    to_pos();
    idle();
    @(negedge clk);
    checks++; if (bus.done_o !== 1'b1) begin errors++; $display("FAIL sw_done: got %b expected 1", bus.done_o); end
    to_pos();
    @(negedge clk);
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL sw_done_pulse: got %b expected 0", bus.done_o); end
    to_pos();
    do_load(32'h40, st, rv, d);
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL lw_stall: got %b expected 1", st); end
    checks++; if (rv !== 1'b1) begin errors++; $display("FAIL lw_rvalid: got %b expected 1", rv); end
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata: got %h expected deadbeef", d); end
    @(negedge clk);
    checks++; if (bus.rvalid_o !== 1'b0) begin errors++; $display("FAIL lw_rvalid_pulse: got %b expected 0", bus.rvalid_o); end
    to_pos();
    do_sw(32'h44, 32'h0BADF00D);
    @(negedge clk);
    checks++; if (bus.rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL rdata_hold: got %h expected deadbeef", bus.rdata_o); end
    to_pos();
  endtask

  task automatic test_mid_reset();
    logic st, rv;
    logic [31:0] d;
    drive(1'b1, 1'b0, 2'b10, 32'h40, 32'h0);
    to_pos();
    idle();
    #2;
    rst_n = 1'b1;
    #1;
    checks++; if (bus.rvalid_o !== 1'b0) begin errors++; $display("FAIL async_rst_rvalid: got %b expected 0", bus.rvalid_o); end
    checks++; if (bus.rdata_o !== 32'h0) begin errors++; $display("FAIL async_rst_rdata: got %h expected 00000000", bus.rdata_o); end
    @(negedge clk);
    rst_n = 1'b0;
    to_pos();
    do_load(32'h40, st, rv, d);
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL array_kept: got %h expected deadbeef", d); end
  endtask

  task automatic test_sub_word();
    logic sa, sw, dw, da, st, rv;
    logic [31:0] d;
    do_sw(32'h80, 32'h11223344);
    do_rmw(2'b00, 32'h81, 32'hFFFFFFAA, sa, sw, dw, da);
    checks++; if (sa !== 1'b1) begin errors++; $display("FAIL sb_stall: got %b expected 1", sa); end
    checks++; if ({sw, dw} !== 2'b00) begin errors++; $display("FAIL sb_wr_cycle: got %b expected 00", {sw, dw}); end
    checks++; if (da !== 1'b1) begin errors++; $display("FAIL sb_done: got %b expected 1", da); end
    do_load(32'h80, st, rv, d);
    checks++; if (d !== 32'h1122AA44) begin errors++; $display("FAIL sb_merge: got %h expected 1122aa44", d); end
    do_rmw(2'b00, 32'h83, 32'h0000005A, sa, sw, dw, da);
    do_load(32'h80, st, rv, d);
    checks++; if (d !== 32'h5A22AA44) begin errors++; $display("FAIL sb_lane3: got %h expected 5a22aa44", d); end
  endtask

  task automatic test_half_and_err();
    logic sa, sw, dw, da, st, rv;
    logic [31:0] d;
    logic [1:0]  esz [3];
    logic [31:0] ead [3];
    logic        ewe [3];
    esz = '{2'b01, 2'b11, 2'b10};
    ead = '{32'h81, 32'h80, 32'h82};
    ewe = '{1'b1, 1'b1, 1'b0};
    do_sw(32'h80, 32'h11223344);
    do_rmw(2'b01, 32'h82, 32'h0000BEEF, sa, sw, dw, da);
    checks++; if ({sa, da} !== 2'b11) begin errors++; $display("FAIL sh_hi_hs: got %b expected 11", {sa, da}); end
    do_load(32'h80, st, rv, d);
    checks++; if (d !== 32'hBEEF3344) begin errors++; $display("FAIL sh_hi: got %h expected beef3344", d); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ewe[i], esz[i], ead[i], 32'h0000CAFE);
      @(negedge clk);
      checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL err%0d_stall: got %b expected 1", i, bus.stall_o); end
      to_pos();
      idle();
      @(negedge clk);
      checks++; if ({bus.err_o, bus.stall_o, bus.done_o, bus.rvalid_o} !== 4'b1000) begin errors++; $display("FAIL err%0d_resp: got %b expected 1000", i, {bus.err_o, bus.stall_o, bus.done_o, bus.rvalid_o}); end
      to_pos();
      @(negedge clk);
      checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL err%0d_pulse: got %b expected 0", i, bus.err_o); end
      to_pos();
    end
    do_load(32'h80, st, rv, d);
    checks++; if (d !== 32'hBEEF3344) begin errors++; $display("FAIL err_unchanged: got %h expected beef3344", d); end
    do_rmw(2'b01, 32'h80, 32'h00001234, sa, sw, dw, da);
    do_load(32'h80, st, rv, d);
    checks++; if (d !== 32'hBEEF1234) begin errors++; $display("FAIL sh_lo: got %h expected beef1234", d); end
  endtask

  task automatic test_wrap();
    logic st, rv;
    logic [31:0] d;
    do_sw(32'h0, 32'h12345678);
    do_sw(DEPTH_WORDS * 4, 32'hCAFEF00D);
    do_load(32'h0, st, rv, d);
    checks++; if (d !== 32'hCAFEF00D) begin errors++; $display("FAIL wrap: got %h expected cafef00d", d); end
  endtask

  task automatic test_back_to_back();
    logic st, rv;
    logic [31:0] d;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 2'b10, 32'h100 + 32'(i * 4), 32'hA0000000 + 32'(i));
      @(negedge clk);
      checks++; if ({bus.stall_o, bus.done_o} !== {1'b0, (i != 0)}) begin errors++; $display("FAIL b2b%0d: got %b expected %b", i, {bus.stall_o, bus.done_o}, {1'b0, (i != 0)}); end
      to_pos();
    end
    idle();
    @(negedge clk);
    checks++; if (bus.done_o !== 1'b1) begin errors++; $display("FAIL b2b_last_done: got %b expected 1", bus.done_o); end
    to_pos();
    do_load(32'h104, st, rv, d);
    checks++; if (d !== 32'hA0000001) begin errors++; $display("FAIL b2b_data: got %h expected a0000001", d); end
  endtask

  task automatic test_rmw_reset();
    logic st, rv;
    logic [31:0] d;
    do_sw(32'hC0, 32'h55667788);
    drive(1'b1, 1'b1, 2'b00, 32'hC1, 32'h00000099);
    to_pos();
    idle();
    #2;
    rst_n = 1'b1;
    #1;
    checks++; if ({bus.stall_o, bus.done_o} !== 2'b00) begin errors++; $display("FAIL rmw_rst_out: got %b expected 00", {bus.stall_o, bus.done_o}); end
    to_pos();
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL rmw_rst_done: got %b expected 0", bus.done_o); end
    @(negedge clk);
    rst_n = 1'b0;
    to_pos();
    do_load(32'hC0, st, rv, d);
    checks++; if (d !== 32'h55667788) begin errors++; $display("FAIL rmw_rst_word: got %h expected 55667788", d); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    test_reset();
    test_word_store_load();
    test_mid_reset();
    test_sub_word();
    test_half_and_err();
    test_wrap();
    test_back_to_back();
    test_rmw_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
